// File: rtl/mult_pkg.sv
// Shared types and defaults for the mult8_seq multiplier front-end.
package mult_pkg;

  localparam int OP_W            = 8;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand FIFO holding {a,b} pairs; no bypass, refuses push when full.
module op_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 2 * OP_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult8_seq.sv
// Sequencer in front of the iterative 8-bit multiplier: queues operand pairs,
// runs one multiply at a time, and hands back products (or timeout aborts).
module mult8_seq
  import mult_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  output logic            mul_start,
  output logic [OP_W-1:0] mul_a,
  output logic [OP_W-1:0] mul_b,
  input  logic            mul_done,
  input  logic [OP_W-1:0] mul_product,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [OP_W-1:0] res_product,
  output logic            res_err,
  output logic            busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_t        state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_next;
  logic [2*OP_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;

  assign pop      = (state == IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_count != '0);
  assign tmo_next = tmo_cnt + TMO_W'(1);

  op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * OP_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .pop     (pop),
    .wr_data ({in_a, in_b}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Operation FSM with registered multiplier drive, timeout counter and result register.
  // mul_done is not looked at in START: it may still be high from the previous product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_valid   <= 1'b0;
      res_product <= '0;
      res_err     <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            mul_a     <= head[2*OP_W-1:OP_W];
            mul_b     <= head[OP_W-1:0];
            mul_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_next;
          if (mul_done) begin
            res_product <= mul_product;
            res_err     <= 1'b0;
            res_valid   <= 1'b1;
            state       <= OUT;
          end else if (tmo_next == TMO_W'(TIMEOUT)) begin
            res_product <= '0;
            res_err     <= 1'b1;
            res_valid   <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq.sv
// Directed bench for mult8_seq with a behavioural 8-cycle shift-add multiplier model.
`timescale 1ns/1ps
module tb_mult8_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic       mul_start;
  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic       mul_done;
  logic [7:0] mul_product;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_product;
  logic       res_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult8_seq #(.DEPTH(4), .TIMEOUT(31)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
    .res_err     (res_err),
    .busy        (busy)
  );

  // Multiplier model: done drops at the start edge and rises 8 cycles later.
  logic       mdl_busy;
  logic       mdl_hang = 1'b0;
  logic [3:0] mdl_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done    <= 1'b0;
      mul_product <= 8'd0;
      mdl_busy    <= 1'b0;
      mdl_cnt     <= 4'd0;
    end else if (mul_start) begin
      mul_done <= 1'b0;
      mdl_busy <= 1'b1;
      mdl_cnt  <= 4'd1;
    end else if (mdl_busy && !mdl_hang) begin
      if (mdl_cnt == 4'd8) begin
        mul_done    <= 1'b1;
        mul_product <= mul_a * mul_b;
        mdl_busy    <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt + 4'd1;
      end
    end
  end

  // Result log and start-pulse counter.
  logic [7:0] got_p[$];
  logic       got_e[$];
  int         start_cnt = 0;
  always @(posedge clk) begin
    if (res_valid && res_ready) begin
      got_p.push_back(res_product);
      got_e.push_back(res_err);
    end
    if (mul_start) start_cnt <= start_cnt + 1;
  end

  // All tasks start and end just after a falling edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b, output bit acc);
    in_a = a; in_b = b; in_valid = 1'b1;
    acc = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (res_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && !res_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b exp 0", mul_start); end
    checks++; if ({mul_a, mul_b} !== 16'h0000) begin errors++; $display("FAIL reset_mul_ops got %h exp 0000", {mul_a, mul_b}); end
    checks++; if ({res_err, res_product} !== 9'h000) begin errors++; $display("FAIL reset_result got %h exp 000", {res_err, res_product}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int ks = -1; int kv = -1; int nstart = 0;
    logic [7:0] p = 8'hxx; logic e = 1'bx; logic [15:0] ops = 16'hxxxx;
    res_ready = 1'b1;
    in_a = 8'd3; in_b = 8'd5; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mul_start) begin nstart++; if (ks < 0) begin ks = k; ops = {mul_a, mul_b}; end end
      if (res_valid && kv < 0) begin kv = k; p = res_product; e = res_err; end
    end
    checks++; if (ks != 1) begin errors++; $display("FAIL single_start_cycle got %0d exp 1", ks); end
    checks++; if (nstart != 1) begin errors++; $display("FAIL single_start_pulses got %0d exp 1", nstart); end
    checks++; if (ops !== 16'h0305) begin errors++; $display("FAIL single_mul_ops got %h exp 0305", ops); end
    checks++; if (kv != 11) begin errors++; $display("FAIL single_valid_cycle got %0d exp 11", kv); end
    checks++; if (p !== 8'h0F) begin errors++; $display("FAIL single_product got %h exp 0f", p); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", e); end
  endtask

  task automatic test_wrap();
    bit acc; bit found;
    res_ready = 1'b1;
    push(8'd20, 8'd20, acc);
    wait_valid(40, found);
    checks++; if (!found) begin errors++; $display("FAIL wrap_valid got 0 exp 1"); end
    checks++; if (res_product !== 8'h90) begin errors++; $display("FAIL wrap_product got %h exp 90", res_product); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", res_err); end
  endtask

  task automatic test_fill();
    bit acc; bit found; int nacc = 0; int base;
    logic [7:0] exp_p[5] = '{8'd2, 8'd12, 8'd30, 8'd56, 8'd90};
    wait_idle(found);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(8'(2 * i + 1), 8'(2 * i + 2), acc);
      if (acc) nacc++;
    end
    checks++; if (nacc != 5) begin errors++; $display("FAIL fill_accepted got %0d exp 5", nacc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_in_ready got %b exp 0", in_ready); end
    wait_valid(40, found);
    checks++; if (!found) begin errors++; $display("FAIL fill_first_valid got 0 exp 1"); end
    push(8'd11, 8'd12, acc);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL fill_sixth_refused got %b exp 0", acc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", busy); end
    base = got_p.size();
    res_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (got_p.size() >= base + 5) break;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    checks++; if (got_p.size() != base + 5) begin errors++; $display("FAIL fill_result_count got %0d exp 5", got_p.size() - base); end
    for (int i = 0; i < 5; i++) begin
      if (base + i < got_p.size()) begin
        checks++;
        if (got_p[base + i] !== exp_p[i] || got_e[base + i] !== 1'b0) begin
          errors++; $display("FAIL fill_result%0d got %h/%b exp %h/0", i, got_p[base + i], got_e[base + i], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc; bit found; int s0; int bad = 0; int base;
    wait_idle(found);
    res_ready = 1'b0;
    push(8'd6, 8'd7, acc);
    wait_valid(40, found);
    checks++; if (!found) begin errors++; $display("FAIL bp_valid got 0 exp 1"); end
    s0 = start_cnt;
    push(8'd1, 8'd1, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_push_accepted got %b exp 1", acc); end
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_product !== 8'h2A || res_err !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles exp 0", bad); end
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL bp_no_start got %0d pulses exp 0", start_cnt - s0); end
    base = got_p.size();
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (got_p.size() != base + 1) begin errors++; $display("FAIL bp_delivered got %0d exp 1", got_p.size() - base); end
    else begin
      checks++; if (got_p[base] !== 8'h2A) begin errors++; $display("FAIL bp_product got %h exp 2a", got_p[base]); end
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_cleared got %b exp 0", res_valid); end
  endtask

  task automatic test_timeout();
    bit acc; bit found; int n = 0; bit seen = 1'b0;
    wait_idle(found);
    res_ready = 1'b1;
    mdl_hang = 1'b1;
    push(8'd11, 8'd13, acc);
    for (int i = 0; i < 10; i++) begin
      if (mul_start) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_start got 0 exp 1"); end
    push(8'd2, 8'd3, acc);
    n = 1;
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    mdl_hang = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL tmo_cycles got %0d exp 32", n); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", res_err); end
    checks++; if (res_product !== 8'h00) begin errors++; $display("FAIL tmo_product got %h exp 00", res_product); end
    @(negedge clk);
    wait_valid(40, found);
    checks++; if (!found) begin errors++; $display("FAIL tmo_next_valid got 0 exp 1"); end
    checks++; if (res_product !== 8'h06 || res_err !== 1'b0) begin
      errors++; $display("FAIL tmo_next_result got %h/%b exp 06/0", res_product, res_err);
    end
  endtask

  task automatic test_reset_mid();
    bit acc; bit found; int s0; int base;
    wait_idle(found);
    res_ready = 1'b0;
    push(8'd4, 8'd4, acc);
    push(8'd5, 8'd5, acc);
    push(8'd6, 8'd6, acc);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl got %b%b exp 00", res_valid, mul_start);
    end
    checks++; if ({mul_a, mul_b} !== 16'h0000) begin errors++; $display("FAIL rmid_mul_ops got %h exp 0000", {mul_a, mul_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt;
    base = got_p.size();
    res_ready = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (got_p.size() != base) begin errors++; $display("FAIL rmid_no_result got %0d exp 0", got_p.size() - base); end
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL rmid_no_start got %0d exp 0", start_cnt - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fill();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation time limit");
  end

endmodule
